// File: rtl/bf_relax_engine_if.sv
// -----------------------------------------------------------------------------
// bf_relax_engine_if
//   Bundles the compute-interface signals between the path controller (master)
//   and the Bellman-Ford relaxation engine (slave). It also carries the
//   edge-list ROM port, which the engine drives and the ROM answers.
//
//   Controller -> engine : clear, enable, stg1_mux_control, source_address,
//                          predecessor_rd_addr
//   Engine -> controller : predecessor_out, done, neg_cycle
//   Engine -> edge ROM   : edge_rd_addr
//   Edge ROM -> engine   : edge_src, edge_dst, edge_wt (1-cycle latency)
// -----------------------------------------------------------------------------
interface bf_relax_engine_if #(
  parameter int NUM_EDGES = 64,
  parameter int DIST_W    = 8,
  parameter int ADDR_W    = 5
);
  localparam int EDGE_AW = $clog2(NUM_EDGES);

  logic                      clear;
  logic                      enable;
  logic                      stg1_mux_control;
  logic [ADDR_W-1:0]         source_address;
  logic [ADDR_W-1:0]         predecessor_rd_addr;
  logic [ADDR_W-1:0]         predecessor_out;
  logic [EDGE_AW-1:0]        edge_rd_addr;
  logic [ADDR_W-1:0]         edge_src;
  logic [ADDR_W-1:0]         edge_dst;
  logic signed [DIST_W-1:0]  edge_wt;
  logic                      done;
  logic                      neg_cycle;

  // Controller side (also hosts the edge ROM).
  modport master (
    output clear, enable, stg1_mux_control, source_address, predecessor_rd_addr,
    output edge_src, edge_dst, edge_wt,
    input  predecessor_out, edge_rd_addr, done, neg_cycle
  );

  // Engine side.
  modport slave (
    input  clear, enable, stg1_mux_control, source_address, predecessor_rd_addr,
    input  edge_src, edge_dst, edge_wt,
    output predecessor_out, edge_rd_addr, done, neg_cycle
  );
endinterface

// File: rtl/bf_relax_engine.sv
// -----------------------------------------------------------------------------
// bf_relax_engine
//   Bellman-Ford relaxation engine. After clear, and while enable is high, it
//   streams the external edge ROM one edge per two cycles (FETCH, RELAX). It
//   relaxes dist/pred in place and repeats whole passes until a pass makes no
//   update or NUM_NODES-2 passes have run, then raises done. The predecessor
//   table can be read at any time through a registered port.
//
//   Ports: clk, reset (async, active high), ifc (bf_relax_engine_if.slave):
//     clear/enable/stg1_mux_control/source_address  run control
//     predecessor_rd_addr -> predecessor_out        1-cycle registered read
//     edge_rd_addr -> edge_src/edge_dst/edge_wt     edge ROM, 1-cycle latency
//     done, neg_cycle                               status
//
//   Optional feature macro: BF_NEG_CYCLE_DETECT_EN
//     When defined, an exit on the pass limit is followed by one extra
//     write-suppressed pass. Any edge that would still relax in that pass
//     sets neg_cycle. When undefined, neg_cycle is tied low.
// -----------------------------------------------------------------------------
module bf_relax_engine #(
  parameter int NUM_NODES = 32,
  parameter int NUM_EDGES = 64,
  parameter int DIST_W    = 8,
  parameter int ADDR_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  bf_relax_engine_if.slave ifc
);

  localparam int EDGE_AW = $clog2(NUM_EDGES);
  localparam int PASS_W  = ADDR_W + 1;

  typedef logic signed [DIST_W-1:0] dist_t;
  typedef logic signed [DIST_W:0]   sum_t;
  typedef logic [ADDR_W-1:0]        node_t;

  localparam dist_t INF     = dist_t'((2 ** (DIST_W - 1)) - 1);
  // Sums saturate one below INF so a relaxed node never looks unreachable.
  localparam sum_t  SUM_MAX = sum_t'((2 ** (DIST_W - 1)) - 2);
  localparam sum_t  SUM_MIN = sum_t'(-(2 ** (DIST_W - 1)));
  localparam logic [EDGE_AW-1:0] LAST_EDGE = EDGE_AW'(NUM_EDGES - 1);
  localparam logic [PASS_W-1:0]  MAX_PASS  = PASS_W'(NUM_NODES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RELAX,
    S_PASS_END,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [EDGE_AW-1:0]   edge_idx_q, edge_idx_d;
  logic [EDGE_AW-1:0]   edge_addr_q, edge_addr_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic                 pass_upd_q, pass_upd_d;
  node_t                source_q, source_d;
  node_t                pred_out_q, pred_out_d;
  logic                 done_q, done_d;
  dist_t                dist_q [NUM_NODES];
  dist_t                dist_d [NUM_NODES];
  node_t                pred_q [NUM_NODES];
  node_t                pred_d [NUM_NODES];
`ifdef BF_NEG_CYCLE_DETECT_EN
  logic                 check_q, check_d;  // in the write-suppressed check pass
  logic                 neg_q, neg_d;
`endif

  // ---------------------------------------------------------------------------
  // Relaxation datapath for the edge currently presented by the ROM.
  // ---------------------------------------------------------------------------
  node_t  u, v;
  dist_t  wt, dist_u, dist_v, sum_clamped;
  sum_t   sum_wide;
  logic   relax_hit;
  logic   run_ok;

  assign u        = ifc.edge_src;
  assign v        = ifc.edge_dst;
  assign wt       = ifc.edge_wt;
  assign dist_u   = dist_q[u];
  assign dist_v   = dist_q[v];
  // One extra bit so that the add itself cannot wrap before clamping.
  assign sum_wide = sum_t'(dist_u) + sum_t'(wt);
  assign run_ok   = ifc.enable && !ifc.stg1_mux_control;

  // NOTE: every variable driven in an always_comb gets a default before any
  // branch; otherwise a missed path holds its old value and infers a latch.
  always_comb begin
    sum_clamped = sum_wide[DIST_W-1:0];
    if (sum_wide > SUM_MAX) begin
      sum_clamped = SUM_MAX[DIST_W-1:0];
    end else if (sum_wide < SUM_MIN) begin
      sum_clamped = SUM_MIN[DIST_W-1:0];
    end
  end

  assign relax_hit = (dist_u != INF) && (u != '0) && (v != '0) &&
                     (v != source_q) && (sum_clamped < dist_v);

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    edge_idx_d  = edge_idx_q;
    edge_addr_d = edge_addr_q;
    pass_d      = pass_q;
    pass_upd_d  = pass_upd_q;
    source_d    = source_q;
    dist_d      = dist_q;
    pred_d      = pred_q;
`ifdef BF_NEG_CYCLE_DETECT_EN
    check_d     = check_q;
    neg_d       = neg_q;
`endif

    // Node 0 means "no predecessor", so its read is forced to 0.
    pred_out_d = (ifc.predecessor_rd_addr == '0) ? '0
                                                 : pred_q[ifc.predecessor_rd_addr];
    // done follows the DONE state by one cycle and drops on clear.
    done_d     = (state_q == S_DONE) && !ifc.clear;

    if (ifc.clear) begin
      source_d    = ifc.source_address;
      edge_idx_d  = '0;
      edge_addr_d = '0;
      pass_d      = '0;
      pass_upd_d  = 1'b0;
      state_d     = S_IDLE;
      for (int i = 0; i < NUM_NODES; i++) begin
        dist_d[i] = (ADDR_W'(i) == ifc.source_address) ? '0 : INF;
        pred_d[i] = '0;
      end
`ifdef BF_NEG_CYCLE_DETECT_EN
      check_d = 1'b0;
      neg_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run_ok) begin
            edge_addr_d = edge_idx_q;
            state_d     = S_FETCH;
          end
        end

        // The address is held here; a stall simply waits with the ROM
        // output still valid for the pending edge.
        S_FETCH: begin
          if (run_ok) begin
            state_d = S_RELAX;
          end
        end

        S_RELAX: begin
          if (ifc.stg1_mux_control) begin
            // Walk mode took over: drop this edge without writing and
            // retry it once the controller releases the table.
            state_d = S_FETCH;
          end else begin
            if (relax_hit) begin
`ifdef BF_NEG_CYCLE_DETECT_EN
              if (check_q) begin
                neg_d = 1'b1;
              end else begin
                dist_d[v]  = sum_clamped;
                pred_d[v]  = u;
                pass_upd_d = 1'b1;
              end
`else
              dist_d[v]  = sum_clamped;
              pred_d[v]  = u;
              pass_upd_d = 1'b1;
`endif
            end
            if (edge_idx_q == LAST_EDGE) begin
              state_d = S_PASS_END;
            end else begin
              edge_idx_d  = edge_idx_q + 1'b1;
              edge_addr_d = edge_idx_q + 1'b1;
              state_d     = S_FETCH;
            end
          end
        end

        S_PASS_END: begin
          pass_d      = pass_q + 1'b1;
          edge_idx_d  = '0;
          edge_addr_d = '0;
`ifdef BF_NEG_CYCLE_DETECT_EN
          if (check_q || !pass_upd_q) begin
            state_d = S_DONE;
          end else if (pass_d == MAX_PASS) begin
            // Still converging at the pass limit: one more read-only pass.
            check_d    = 1'b1;
            pass_upd_d = 1'b0;
            state_d    = S_FETCH;
          end else begin
            pass_upd_d = 1'b0;
            state_d    = S_FETCH;
          end
`else
          if (!pass_upd_q || (pass_d == MAX_PASS)) begin
            state_d = S_DONE;
          end else begin
            pass_upd_d = 1'b0;
            state_d    = S_FETCH;
          end
`endif
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      edge_idx_q  <= '0;
      edge_addr_q <= '0;
      pass_q      <= '0;
      pass_upd_q  <= 1'b0;
      source_q    <= '0;
      pred_out_q  <= '0;
      done_q      <= 1'b0;
      // NOTE: the dist/pred tables are plain flops, not RAM, because a reset
      // must leave them in a known state (all unreachable, no predecessors).
      for (int i = 0; i < NUM_NODES; i++) begin
        dist_q[i] <= INF;
        pred_q[i] <= '0;
      end
`ifdef BF_NEG_CYCLE_DETECT_EN
      check_q     <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      edge_idx_q  <= edge_idx_d;
      edge_addr_q <= edge_addr_d;
      pass_q      <= pass_d;
      pass_upd_q  <= pass_upd_d;
      source_q    <= source_d;
      pred_out_q  <= pred_out_d;
      done_q      <= done_d;
      dist_q      <= dist_d;
      pred_q      <= pred_d;
`ifdef BF_NEG_CYCLE_DETECT_EN
      check_q     <= check_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign ifc.predecessor_out = pred_out_q;
  assign ifc.edge_rd_addr    = edge_addr_q;
  assign ifc.done            = done_q;
`ifdef BF_NEG_CYCLE_DETECT_EN
  assign ifc.neg_cycle       = neg_q;
`else
  assign ifc.neg_cycle       = 1'b0;
`endif

endmodule
